// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF) and load/store (D), one transaction in flight.
// Define ARB_STARVE_GUARD_EN to let IF win after STARVE_LIMIT consecutive D wins over a pending IF request.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                if_req_ip,
  input  logic [ADDR_W-1:0]   if_addr_ip,
  output logic                if_gnt_op,
  output logic                if_rvalid_op,
  output logic [DATA_W-1:0]   if_rdata_op,
  input  logic                d_req_ip,
  input  logic                d_we_ip,
  input  logic [DATA_W/8-1:0] d_be_ip,
  input  logic [ADDR_W-1:0]   d_addr_ip,
  input  logic [DATA_W-1:0]   d_wdata_ip,
  output logic                d_gnt_op,
  output logic                d_rvalid_op,
  output logic [DATA_W-1:0]   d_rdata_op,
  output logic                mem_req_op,
  output logic                mem_we_op,
  output logic [DATA_W/8-1:0] mem_be_op,
  output logic [ADDR_W-1:0]   mem_addr_op,
  output logic [DATA_W-1:0]   mem_wdata_op,
  input  logic                mem_gnt_ip,
  input  logic                mem_rvalid_ip,
  input  logic [DATA_W-1:0]   mem_rdata_ip,
  output logic                spurious_op
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state;
  logic owner_d;
  logic d_wins;
`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;
  logic          starved;
  assign starved = starve_cnt == CW'(STARVE_LIMIT);
  assign d_wins  = d_req_ip & ~(if_req_ip & starved);
  // Counts only D wins that overtook a waiting IF; anything else resets the streak.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) starve_cnt <= '0;
    else if (state == IDLE) starve_cnt <= (d_wins & if_req_ip) ? (starved ? starve_cnt : starve_cnt + 1'b1) : '0;
`else
  assign d_wins = d_req_ip;
`endif
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner_d      <= 1'b0;
      spurious_op  <= 1'b0;
      mem_req_op   <= 1'b0;
      mem_we_op    <= 1'b0;
      mem_be_op    <= '0;
      mem_addr_op  <= '0;
      mem_wdata_op <= '0;
    end else begin
      if (state == IDLE && mem_rvalid_ip) spurious_op <= 1'b1;
      case (state)
        IDLE: if (d_req_ip | if_req_ip) begin
          state        <= REQ;
          owner_d      <= d_wins;
          mem_req_op   <= 1'b1;
          mem_we_op    <= d_wins & d_we_ip;
          mem_be_op    <= d_wins ? d_be_ip : '1;
          mem_addr_op  <= d_wins ? d_addr_ip : if_addr_ip;
          mem_wdata_op <= d_wins ? d_wdata_ip : '0;
        end
        REQ: if (mem_gnt_ip) begin
          mem_req_op <= 1'b0;
          state      <= mem_rvalid_ip ? IDLE : RESP;
        end
        RESP: if (mem_rvalid_ip) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign if_gnt_op    = mem_req_op & mem_gnt_ip & ~owner_d;
  assign d_gnt_op     = mem_req_op & mem_gnt_ip & owner_d;
  assign if_rvalid_op = mem_rvalid_ip & (state != IDLE) & ~owner_d;
  assign d_rvalid_op  = mem_rvalid_ip & (state != IDLE) & owner_d;
  assign if_rdata_op  = mem_rdata_ip;
  assign d_rdata_op   = mem_rdata_ip;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transactions checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, BW = DW / 8, LIM = 4;
  logic clock = 1'b0, reset_n = 1'b0;
  logic if_req_ip = 1'b0, d_req_ip = 1'b0, d_we_ip = 1'b0;
  logic [AW-1:0] if_addr_ip = '0, d_addr_ip = '0;
  logic [BW-1:0] d_be_ip = '0;
  logic [DW-1:0] d_wdata_ip = '0, mem_rdata_ip = '0;
  logic mem_gnt_ip = 1'b0, mem_rvalid_ip = 1'b0;
  logic if_gnt_op, if_rvalid_op, d_gnt_op, d_rvalid_op, mem_req_op, mem_we_op, spurious_op;
  logic [DW-1:0] if_rdata_op, d_rdata_op, mem_wdata_op;
  logic [BW-1:0] mem_be_op;
  logic [AW-1:0] mem_addr_op;
  int checks = 0, passed = 0;
  bit p_if = 0, p_d = 0, e_we = 0, got_d;
  logic [AW-1:0] e_if_addr = '0, e_d_addr = '0;
  logic [BW-1:0] e_be = '0;
  logic [DW-1:0] e_wdata = '0;
  int starve = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req_ip(if_req_ip), .if_addr_ip(if_addr_ip), .if_gnt_op(if_gnt_op), .if_rvalid_op(if_rvalid_op), .if_rdata_op(if_rdata_op),
    .d_req_ip(d_req_ip), .d_we_ip(d_we_ip), .d_be_ip(d_be_ip), .d_addr_ip(d_addr_ip), .d_wdata_ip(d_wdata_ip),
    .d_gnt_op(d_gnt_op), .d_rvalid_op(d_rvalid_op), .d_rdata_op(d_rdata_op),
    .mem_req_op(mem_req_op), .mem_we_op(mem_we_op), .mem_be_op(mem_be_op), .mem_addr_op(mem_addr_op), .mem_wdata_op(mem_wdata_op),
    .mem_gnt_ip(mem_gnt_ip), .mem_rvalid_ip(mem_rvalid_ip), .mem_rdata_ip(mem_rdata_ip), .spurious_op(spurious_op)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive();
    if_req_ip = p_if; if_addr_ip = e_if_addr;
    d_req_ip = p_d; d_we_ip = e_we; d_be_ip = e_be; d_addr_ip = e_d_addr; d_wdata_ip = e_wdata;
  endtask

  task automatic new_if(input logic [AW-1:0] a);
    p_if = 1; e_if_addr = a;
  endtask

  task automatic new_d(input bit we, input logic [BW-1:0] be, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    p_d = 1; e_we = we; e_be = be; e_d_addr = a; e_wdata = wd;
  endtask

  // Runs one transaction from the IDLE cycle in which requests are already driven; ends in the next IDLE cycle.
  task automatic do_txn(input int gd, input int rd, input logic [DW-1:0] rdat, output bit obs_d);
    bit wd;
    logic [AW-1:0] ea;
    wd = p_d;
`ifdef ARB_STARVE_GUARD_EN
    if (p_d && p_if && starve == LIM) wd = 0;
    starve = (wd && p_if) ? ((starve == LIM) ? LIM : starve + 1) : 0;
`endif
    ea = wd ? e_d_addr : e_if_addr;
    step();
    for (int k = 0; k <= gd; k++) begin
      checks++;
      if ({mem_req_op, mem_we_op, mem_addr_op} !== {1'b1, wd & e_we, ea})
        $display("FAIL mem_fields: got req=%b we=%b addr=%h want req=1 we=%b addr=%h", mem_req_op, mem_we_op, mem_addr_op, wd & e_we, ea);
      else passed++;
      if (wd) begin
        checks++;
        if ({mem_be_op, mem_wdata_op} !== {e_be, e_wdata})
          $display("FAIL mem_be_wdata: got be=%b wdata=%h want be=%b wdata=%h", mem_be_op, mem_wdata_op, e_be, e_wdata);
        else passed++;
      end
      if (k < gd) begin
        checks++;
        if ({if_gnt_op, d_gnt_op} !== 2'b00) $display("FAIL early_gnt: got if/d=%b%b want 00", if_gnt_op, d_gnt_op);
        else passed++;
        step();
      end
    end
    mem_gnt_ip = 1; mem_rdata_ip = rdat; mem_rvalid_ip = (rd == 0);
    #1;
    obs_d = d_gnt_op;
    checks++;
    if ({if_gnt_op, d_gnt_op} !== {!wd, wd}) $display("FAIL gnt_route: got if/d=%b%b want %b%b", if_gnt_op, d_gnt_op, !wd, wd);
    else passed++;
    if (wd) p_d = 0; else p_if = 0;
    if (rd > 0) begin
      checks++;
      if ({if_rvalid_op, d_rvalid_op} !== 2'b00) $display("FAIL early_rvalid: got if/d=%b%b want 00", if_rvalid_op, d_rvalid_op);
      else passed++;
      step();
      mem_gnt_ip = 0; drive();
      checks++;
      if (mem_req_op !== 1'b0) $display("FAIL req_drop: got %b want 0", mem_req_op);
      else passed++;
      for (int k = 1; k < rd; k++) begin
        mem_gnt_ip = 1'($urandom % 2);
        #1;
        checks++;
        if ({if_gnt_op, d_gnt_op, if_rvalid_op, d_rvalid_op} !== 4'b0000)
          $display("FAIL resp_wait: got gnt=%b%b rvalid=%b%b want 0000", if_gnt_op, d_gnt_op, if_rvalid_op, d_rvalid_op);
        else passed++;
        step();
      end
      mem_gnt_ip = 0; mem_rvalid_ip = 1;
      #1;
    end
    checks++;
    if ({if_rvalid_op, d_rvalid_op} !== {!wd, wd}) $display("FAIL rvalid_route: got if/d=%b%b want %b%b", if_rvalid_op, d_rvalid_op, !wd, wd);
    else passed++;
    checks++;
    if ({if_rdata_op, d_rdata_op} !== {rdat, rdat}) $display("FAIL rdata: got if=%h d=%h want %h", if_rdata_op, d_rdata_op, rdat);
    else passed++;
    step();
    mem_gnt_ip = 0; mem_rvalid_ip = 0; drive();
    checks++;
    if ({mem_req_op, spurious_op, if_rvalid_op, d_rvalid_op} !== 4'b0000)
      $display("FAIL back_to_idle: got req=%b spur=%b rvalid=%b%b want 0 0 00", mem_req_op, spurious_op, if_rvalid_op, d_rvalid_op);
    else passed++;
  endtask

  task automatic apply_reset();
    reset_n = 0; p_if = 0; p_d = 0; starve = 0;
    mem_gnt_ip = 0; mem_rvalid_ip = 0; drive();
    step();
    reset_n = 1;
    step();
  endtask

  task automatic test_reset();
    reset_n = 0;
    step();
    step();
    checks++;
    if ({mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op, spurious_op, if_gnt_op, d_gnt_op} !== '0)
      $display("FAIL reset_outputs: got req=%b we=%b be=%b addr=%h wdata=%h spur=%b want all 0", mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op, spurious_op);
    else passed++;
    reset_n = 1;
    step();
  endtask

  task automatic test_if_read();
    new_if(32'h40); drive();
    do_txn(0, 1, 32'hDEADBEEF, got_d);
    checks++;
    if (got_d !== 1'b0) $display("FAIL if_read_owner: got d_gnt=%b want 0", got_d);
    else passed++;
  endtask

  task automatic test_priority();
    bit first_d;
    new_if(32'h80); new_d(0, 4'hF, 32'h200, 32'h0); drive();
    do_txn(1, 2, 32'h11112222, first_d);
    do_txn(0, 1, 32'h33334444, got_d);
    checks++;
    if ({first_d, got_d} !== 2'b10) $display("FAIL priority_order: got d-first=%b d-second=%b want 1 0", first_d, got_d);
    else passed++;
  endtask

  task automatic test_write_hold();
    new_d(1, 4'b0011, 32'h100, 32'h1234); drive();
    do_txn(3, 1, 32'h0, got_d);
  endtask

  task automatic test_gnt_rvalid_same();
    new_d(0, 4'hF, 32'h300, 32'h0); drive();
    do_txn(0, 0, 32'hCAFEF00D, got_d);
    new_if(32'h44); drive();
    do_txn(0, 0, 32'h0BADF00D, got_d);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      if (!p_if && ($urandom % 2)) new_if({$urandom, 2'b00} & 32'hFFFF_FFFC);
      if (!p_d && ($urandom % 2)) new_d(1'($urandom % 2), 4'($urandom), $urandom, $urandom);
      if (!p_if && !p_d) new_if(32'h1000 + 32'(n) * 4);
      drive();
      do_txn(int'($urandom % 4), int'($urandom % 4), $urandom, got_d);
    end
  endtask

  task automatic test_spurious();
    while (p_if || p_d) do_txn(0, 1, 32'h0, got_d);
    mem_rvalid_ip = 1;
    #1;
    checks++;
    if ({if_rvalid_op, d_rvalid_op} !== 2'b00) $display("FAIL spurious_no_fwd: got if/d=%b%b want 00", if_rvalid_op, d_rvalid_op);
    else passed++;
    step();
    mem_rvalid_ip = 0;
    step();
    step();
    checks++;
    if (spurious_op !== 1'b1) $display("FAIL spurious_sticky: got %b want 1", spurious_op);
    else passed++;
    new_if(32'h500); drive();
    step();
    mem_gnt_ip = 1;
    step();
    mem_gnt_ip = 0; p_if = 0; drive();
    reset_n = 0;
    #1;
    checks++;
    if ({mem_req_op, mem_we_op, mem_be_op, mem_addr_op, mem_wdata_op, spurious_op, if_gnt_op, d_gnt_op, if_rvalid_op, d_rvalid_op} !== '0)
      $display("FAIL async_reset: got req=%b addr=%h spur=%b want all 0", mem_req_op, mem_addr_op, spurious_op);
    else passed++;
    step();
    reset_n = 1;
    step();
    mem_rvalid_ip = 1;
    #1;
    checks++;
    if ({if_rvalid_op, d_rvalid_op} !== 2'b00) $display("FAIL late_resp_fwd: got if/d=%b%b want 00", if_rvalid_op, d_rvalid_op);
    else passed++;
    step();
    mem_rvalid_ip = 0;
    checks++;
    if (spurious_op !== 1'b1) $display("FAIL late_resp_spurious: got %b want 1", spurious_op);
    else passed++;
  endtask

  task automatic test_starve();
    bit exp_d;
    apply_reset();
    for (int n = 0; n < 12; n++) begin
      if (!p_if) new_if(32'h2000 + 32'(n) * 4);
      if (!p_d) new_d(1'(n % 2), 4'hF, 32'h3000 + 32'(n) * 4, 32'(n));
      drive();
      do_txn(0, int'($urandom % 2), 32'(n), got_d);
`ifdef ARB_STARVE_GUARD_EN
      exp_d = (n % 5) != 4;
`else
      exp_d = 1;
`endif
      checks++;
      if (got_d !== exp_d) $display("FAIL starve_order[%0d]: got d_gnt=%b want %b", n, got_d, exp_d);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_priority();
    test_write_hold();
    test_gnt_rvalid_same();
    test_random();
    test_spurious();
    test_starve();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
